// File: rtl/pmod_cls_stand_spi_responder_pkg.sv
// Shared types and constants for the PMOD CLS display responder: ASCII codes,
// frame-buffer line type, parser state and escape-parameter helpers.
package pmod_cls_stand_spi_solo_pkg;

    localparam logic [7:0] C_ASCII_ESC      = 8'h1B;
    localparam logic [7:0] C_ASCII_LBRACKET = 8'h5B;
    localparam logic [7:0] C_ASCII_ZERO     = 8'h30;
    localparam logic [7:0] C_ASCII_NINE     = 8'h39;
    localparam logic [7:0] C_ASCII_SEMI     = 8'h3B;
    localparam logic [7:0] C_ASCII_J        = 8'h6A;
    localparam logic [7:0] C_ASCII_H        = 8'h48;
    localparam logic [7:0] C_ASCII_BLANK    = 8'h20;
    localparam logic [7:0] C_ASCII_TILDE    = 8'h7E;

    // Element 15 is column 0 so the packed vector has column 0 in [127:120].
    typedef logic [15:0][7:0] t_pmod_cls_ascii_line_16;

    typedef enum logic [1:0] {
        ST_TEXT = 2'd0,
        ST_ESC  = 2'd1,
        ST_CSI  = 2'd2
    } t_cls_rsp_state;

    typedef logic [7:0] t_cls_rsp_param;

    function automatic t_cls_rsp_param param_accum(input t_cls_rsp_param p,
                                                   input logic [3:0]     digit,
                                                   input t_cls_rsp_param pmax);
        logic [11:0] acc;
        acc = ({4'd0, p} * 12'd10) + {8'd0, digit};
        if (acc > {4'd0, pmax}) begin
            return pmax;
        end else begin
            return acc[7:0];
        end
    endfunction

    function automatic logic [3:0] col_slot(input logic [4:0] col);
        return 4'(5'd15 - col);
    endfunction

endpackage

// File: rtl/pmod_cls_stand_spi_responder_if.sv
// SPI Mode 0 pin bundle between the CLS driver's SPI master and the responder.
interface pmod_cls_stand_spi_responder_if;
    logic i_sck;
    logic i_cs_n;
    logic i_mosi;

    modport master (output i_sck, output i_cs_n, output i_mosi);
    modport slave  (input  i_sck, input  i_cs_n, input  i_mosi);
endinterface

// File: rtl/pmod_cls_spi_slave_rx.sv
// SPI Mode 0 byte receiver: synchronizes the pins, shifts MOSI on SCK rising
// edges while selected, strobes whole bytes and flags partial ones.
module pmod_cls_spi_slave_rx #(
    parameter int parm_sync_stages = 2
) (
    input  logic       i_ext_spi_clk_x,
    input  logic       i_arst_n,
    input  logic       i_sck,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_partial_error
);

    logic [parm_sync_stages-1:0] sck_sync_r;
    logic [parm_sync_stages-1:0] cs_sync_r;
    logic [parm_sync_stages-1:0] mosi_sync_r;
    logic       sck_prev_r;
    logic       cs_prev_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic [7:0] byte_data_r;
    logic       byte_valid_r;
    logic       part_err_r;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise_s;
    logic cs_rise_s;

    assign sck_s  = sck_sync_r[parm_sync_stages-1];
    assign cs_s   = cs_sync_r[parm_sync_stages-1];
    assign mosi_s = mosi_sync_r[parm_sync_stages-1];

    // An edge still counts in the cycle cs_n rises, so a byte finished together with deselect is kept.
    assign sck_rise_s = sck_s & ~sck_prev_r & ~(cs_s & cs_prev_r);
    assign cs_rise_s  = cs_s & ~cs_prev_r;

    // Pin synchronizer chains.
    always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sck_sync_r  <= '0;
            cs_sync_r   <= '0;
            mosi_sync_r <= '0;
        end else begin
            sck_sync_r  <= {sck_sync_r[parm_sync_stages-2:0], i_sck};
            cs_sync_r   <= {cs_sync_r[parm_sync_stages-2:0], i_cs_n};
            mosi_sync_r <= {mosi_sync_r[parm_sync_stages-2:0], i_mosi};
        end
    end

    // Edge history, bit counter, shift register and byte/error strobes.
    always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sck_prev_r   <= 1'b0;
            cs_prev_r    <= 1'b0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_data_r  <= 8'h00;
            byte_valid_r <= 1'b0;
            part_err_r   <= 1'b0;
        end else begin
            sck_prev_r   <= sck_s;
            cs_prev_r    <= cs_s;
            byte_valid_r <= 1'b0;
            part_err_r   <= 1'b0;
            if (sck_rise_s) begin
                shift_r <= {shift_r[6:0], mosi_s};
                if (bit_cnt_r == 3'd7) begin
                    byte_data_r  <= {shift_r[6:0], mosi_s};
                    byte_valid_r <= 1'b1;
                    bit_cnt_r    <= 3'd0;
                end else if (cs_rise_s) begin
                    part_err_r <= 1'b1;
                    bit_cnt_r  <= 3'd0;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
            end else if (cs_rise_s && (bit_cnt_r != 3'd0)) begin
                part_err_r <= 1'b1;
                bit_cnt_r  <= 3'd0;
            end
        end
    end

    assign o_byte_valid    = byte_valid_r;
    assign o_byte_data     = byte_data_r;
    assign o_partial_error = part_err_r;

endmodule

// File: rtl/pmod_cls_stand_spi_responder.sv
// PMOD CLS device model: receives SPI bytes, parses the CLS escape subset and
// keeps a 2x16 character frame buffer with cursor and event pulses.
module pmod_cls_stand_spi_responder
    import pmod_cls_stand_spi_solo_pkg::*;
#(
    parameter int         parm_sync_stages = 2,
    parameter logic [7:0] parm_blank_char  = 8'h20,
    parameter int         parm_param_max   = 99
) (
    input  logic                          i_ext_spi_clk_x,
    input  logic                          i_arst_n,
    pmod_cls_stand_spi_responder_if.slave spi,
    output logic                          o_byte_valid,
    output logic [7:0]                    o_byte_data,
    output logic [127:0]                  o_dat_ascii_line1,
    output logic [127:0]                  o_dat_ascii_line2,
    output logic                          o_cursor_row,
    output logic [4:0]                    o_cursor_col,
    output logic                          o_evt_clear,
    output logic                          o_evt_cursor,
    output logic                          o_evt_char,
    output logic                          o_evt_error
);

    localparam t_cls_rsp_param          C_PARAM_MAX  = t_cls_rsp_param'(parm_param_max);
    localparam t_pmod_cls_ascii_line_16 C_BLANK_LINE = {16{parm_blank_char}};

    logic       byte_valid_s;
    logic [7:0] byte_s;
    logic       rx_err_s;

    t_cls_rsp_state          state_r,  state_nxt_s;
    t_pmod_cls_ascii_line_16 line1_r,  line1_nxt_s;
    t_pmod_cls_ascii_line_16 line2_r,  line2_nxt_s;
    logic                    row_r,    row_nxt_s;
    logic [4:0]              col_r,    col_nxt_s;
    t_cls_rsp_param          p0_r,     p0_nxt_s;
    t_cls_rsp_param          p1_r,     p1_nxt_s;
    logic                    pidx_r,   pidx_nxt_s;
    logic evt_clear_r,  evt_clear_nxt_s;
    logic evt_cursor_r, evt_cursor_nxt_s;
    logic evt_char_r,   evt_char_nxt_s;
    logic evt_error_r,  evt_error_nxt_s;

    pmod_cls_spi_slave_rx #(
        .parm_sync_stages (parm_sync_stages)
    ) u_rx (
        .i_ext_spi_clk_x (i_ext_spi_clk_x),
        .i_arst_n        (i_arst_n),
        .i_sck           (spi.i_sck),
        .i_cs_n          (spi.i_cs_n),
        .i_mosi          (spi.i_mosi),
        .o_byte_valid    (byte_valid_s),
        .o_byte_data     (byte_s),
        .o_partial_error (rx_err_s)
    );

    // Parser next state, frame-buffer/cursor updates and event decode.
    always_comb begin
        state_nxt_s      = state_r;
        line1_nxt_s      = line1_r;
        line2_nxt_s      = line2_r;
        row_nxt_s        = row_r;
        col_nxt_s        = col_r;
        p0_nxt_s         = p0_r;
        p1_nxt_s         = p1_r;
        pidx_nxt_s       = pidx_r;
        evt_clear_nxt_s  = 1'b0;
        evt_cursor_nxt_s = 1'b0;
        evt_char_nxt_s   = 1'b0;
        evt_error_nxt_s  = 1'b0;
        if (byte_valid_s) begin
            case (state_r)
                ST_TEXT: begin
                    if (byte_s == C_ASCII_ESC) begin
                        state_nxt_s = ST_ESC;
                    end else if ((byte_s >= C_ASCII_BLANK) && (byte_s <= C_ASCII_TILDE)) begin
                        if (col_r < 5'd16) begin
                            if (row_r) begin
                                line2_nxt_s[col_slot(col_r)] = byte_s;
                            end else begin
                                line1_nxt_s[col_slot(col_r)] = byte_s;
                            end
                            col_nxt_s      = col_r + 5'd1;
                            evt_char_nxt_s = 1'b1;
                        end else begin
                            evt_error_nxt_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_TEXT;
                    end
                end
                ST_ESC: begin
                    if (byte_s == C_ASCII_LBRACKET) begin
                        state_nxt_s = ST_CSI;
                        p0_nxt_s    = 8'd0;
                        p1_nxt_s    = 8'd0;
                        pidx_nxt_s  = 1'b0;
                    end else if (byte_s == C_ASCII_ESC) begin
                        state_nxt_s = ST_ESC;
                    end else begin
                        evt_error_nxt_s = 1'b1;
                        state_nxt_s     = ST_TEXT;
                    end
                end
                ST_CSI: begin
                    if ((byte_s >= C_ASCII_ZERO) && (byte_s <= C_ASCII_NINE)) begin
                        if (pidx_r) begin
                            p1_nxt_s = param_accum(p1_r, byte_s[3:0], C_PARAM_MAX);
                        end else begin
                            p0_nxt_s = param_accum(p0_r, byte_s[3:0], C_PARAM_MAX);
                        end
                    end else if (byte_s == C_ASCII_SEMI) begin
                        if (!pidx_r) begin
                            pidx_nxt_s = 1'b1;
                        end else begin
                            evt_error_nxt_s = 1'b1;
                            state_nxt_s     = ST_TEXT;
                        end
                    end else if (byte_s == C_ASCII_ESC) begin
                        state_nxt_s = ST_ESC;
                    end else if (byte_s == C_ASCII_J) begin
                        if (p0_r == 8'd0) begin
                            line1_nxt_s     = C_BLANK_LINE;
                            line2_nxt_s     = C_BLANK_LINE;
                            row_nxt_s       = 1'b0;
                            col_nxt_s       = 5'd0;
                            evt_clear_nxt_s = 1'b1;
                        end else begin
                            evt_error_nxt_s = 1'b1;
                        end
                        state_nxt_s = ST_TEXT;
                    end else if (byte_s == C_ASCII_H) begin
                        row_nxt_s        = (p0_r != 8'd0);
                        col_nxt_s        = (p1_r > 8'd15) ? 5'd15 : p1_r[4:0];
                        evt_cursor_nxt_s = 1'b1;
                        state_nxt_s      = ST_TEXT;
                    end else begin
                        evt_error_nxt_s = 1'b1;
                        state_nxt_s     = ST_TEXT;
                    end
                end
                default: begin
                    state_nxt_s = ST_TEXT;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Parser state, frame buffer, cursor and registered event outputs.
    always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_r      <= ST_TEXT;
            line1_r      <= C_BLANK_LINE;
            line2_r      <= C_BLANK_LINE;
            row_r        <= 1'b0;
            col_r        <= 5'd0;
            p0_r         <= 8'd0;
            p1_r         <= 8'd0;
            pidx_r       <= 1'b0;
            evt_clear_r  <= 1'b0;
            evt_cursor_r <= 1'b0;
            evt_char_r   <= 1'b0;
            evt_error_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            line1_r      <= line1_nxt_s;
            line2_r      <= line2_nxt_s;
            row_r        <= row_nxt_s;
            col_r        <= col_nxt_s;
            p0_r         <= p0_nxt_s;
            p1_r         <= p1_nxt_s;
            pidx_r       <= pidx_nxt_s;
            evt_clear_r  <= evt_clear_nxt_s;
            evt_cursor_r <= evt_cursor_nxt_s;
            evt_char_r   <= evt_char_nxt_s;
            evt_error_r  <= evt_error_nxt_s | rx_err_s;
        end
    end

    assign o_byte_valid      = byte_valid_s;
    assign o_byte_data       = byte_s;
    assign o_dat_ascii_line1 = line1_r;
    assign o_dat_ascii_line2 = line2_r;
    assign o_cursor_row      = row_r;
    assign o_cursor_col      = col_r;
    assign o_evt_clear       = evt_clear_r;
    assign o_evt_cursor      = evt_cursor_r;
    assign o_evt_char        = evt_char_r;
    assign o_evt_error       = evt_error_r;

endmodule
